// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered channel multiplexer with manual select and timed auto-scan
module mux_scan #(
    parameter int WIDTH = 8,
    parameter int CH = 4,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic [SELW-1:0]       se,
    input  logic                  en,
    input  logic                  mode,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [SELW-1:0]       ch
);

    localparam logic [SELW:0]   CH_L       = (SELW + 1)'(CH);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(CH - 1);
    localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_SCAN
    } state_t;

    state_t            state;
    logic [SELW-1:0]   ptr;
    logic [7:0]        dwell;

    logic              se_ok;
    logic [SELW-1:0]   scan_ptr;
    logic [7:0]        scan_dwell;
    logic [SELW-1:0]   pick;
    logic [WIDTH-1:0]  pick_data;

    // Next scan position: reload on entry, otherwise advance once the dwell expires.
    always_comb begin
        se_ok      = {1'b0, se} < CH_L;
        scan_ptr   = ptr;
        scan_dwell = dwell;
        if (state != ST_SCAN) begin
            scan_ptr   = se_ok ? se : '0;
            scan_dwell = '0;
        end else if (dwell == DWELL_LAST) begin
            scan_ptr   = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
            scan_dwell = '0;
        end else begin
            scan_dwell = dwell + 8'd1;
        end

        pick      = mode ? scan_ptr : se;
        pick_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (pick == SELW'(k)) begin
                pick_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            dwell   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ch      <= '0;
        end else if (!en) begin
            state   <= ST_IDLE;
            y       <= '0;
            y_valid <= 1'b0;
            ch      <= '0;
        end else if (!mode) begin
            // Out-of-range selects (non power-of-two CH) report the index but no data.
            state   <= ST_MANUAL;
            y       <= se_ok ? pick_data : '0;
            y_valid <= se_ok;
            ch      <= se;
        end else begin
            state   <= ST_SCAN;
            ptr     <= scan_ptr;
            dwell   <= scan_dwell;
            y       <= pick_data;
            y_valid <= 1'b1;
            ch      <= scan_ptr;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - self-checking bench for mux_scan with a behavioural scan model
module tb_mux_scan;

    logic        clk;
    logic        rst_n;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic [1:0]  se;
    logic        en;
    logic        mode;

    logic [7:0]  y_a, y_b;
    logic        v_a, v_b;
    logic [1:0]  ch_a, ch_b;

    int checks = 0;
    int errors = 0;

    mux_scan #(.WIDTH(8), .CH(4), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .se(se), .en(en), .mode(mode),
        .y(y_a), .y_valid(v_a), .ch(ch_a)
    );

    mux_scan #(.WIDTH(8), .CH(3), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .se(se), .en(en), .mode(mode),
        .y(y_b), .y_valid(v_b), .ch(ch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A scan run is described by its start channel and the number of cycles since entry.
    task automatic model_step(input int chn, input int dwell, input logic [31:0] d,
                              inout bit scan, inout int s0, inout int n,
                              output logic [31:0] ey, output logic [31:0] ev,
                              output logic [31:0] ech);
        int c;
        ey = 0; ev = 0; ech = 0;
        if (!rst_n || !en) begin
            scan = 0;
        end else if (!mode) begin
            scan = 0;
            ech = se;
            if (int'(se) < chn) begin
                ey = (d >> (8 * int'(se))) & 32'hFF;
                ev = 1;
            end
        end else begin
            if (!scan) begin
                s0 = (int'(se) < chn) ? int'(se) : 0;
                n = 0;
                scan = 1;
            end else begin
                n++;
            end
            c = (s0 + n / dwell) % chn;
            ey = (d >> (8 * c)) & 32'hFF;
            ev = 1;
            ech = c;
        end
    endtask

    bit a_scan = 0, b_scan = 0;
    int a_s0 = 0, a_n = 0, b_s0 = 0, b_n = 0;

    // Inputs only change 1 time unit after a falling edge, so at the falling edge
    // they still hold the values the preceding rising edge captured.
    initial forever begin
        logic [31:0] ey, ev, ech;
        @(negedge clk);
        model_step(4, 2, din_a, a_scan, a_s0, a_n, ey, ev, ech);
        chk("model_a_y", {24'h0, y_a}, ey);
        chk("model_a_valid", {31'h0, v_a}, ev);
        chk("model_a_ch", {30'h0, ch_a}, ech);
        model_step(3, 1, {8'h0, din_b}, b_scan, b_s0, b_n, ey, ev, ech);
        chk("model_b_y", {24'h0, y_b}, ey);
        chk("model_b_valid", {31'h0, v_b}, ev);
        chk("model_b_ch", {30'h0, ch_b}, ech);
    end

    task automatic step(input logic e, input logic m, input logic [1:0] s);
        en = e;
        mode = m;
        se = s;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic [7:0] ey, input logic ev,
                            input logic [1:0] ec);
        chk({tag, "_y"}, {24'h0, y_a}, {24'h0, ey});
        chk({tag, "_valid"}, {31'h0, v_a}, {31'h0, ev});
        chk({tag, "_ch"}, {30'h0, ch_a}, {30'h0, ec});
    endtask

    task automatic expect_b(input string tag, input logic [7:0] ey, input logic ev,
                            input logic [1:0] ec);
        chk({tag, "_y"}, {24'h0, y_b}, {24'h0, ey});
        chk({tag, "_valid"}, {31'h0, v_b}, {31'h0, ev});
        chk({tag, "_ch"}, {30'h0, ch_b}, {30'h0, ec});
    endtask

    logic [7:0] scan_y [10];
    logic [1:0] scan_c [10];

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        mode = 1'b0;
        se = 2'd0;
        din_a = 32'h44332211;
        din_b = 24'h332211;
        scan_y = '{8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11, 8'h11, 8'h22, 8'h22};
        scan_c = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};

        @(negedge clk);
        #1;
        expect_a("reset", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd0);
            expect_a("idle", 8'h00, 1'b0, 2'd0);
        end

        step(1'b1, 1'b0, 2'd2);
        expect_a("manual_se2", 8'h33, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd0);
        expect_a("manual_se0", 8'h11, 1'b1, 2'd0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 2'd1);
            expect_a("scan_from1", scan_y[i], 1'b1, scan_c[i]);
        end

        step(1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b1, 2'd1);
        expect_a("scan_at3", 8'h44, 1'b1, 2'd3);
        step(1'b0, 1'b1, 2'd0);
        expect_a("drop_en0", 8'h00, 1'b0, 2'd0);
        step(1'b0, 1'b1, 2'd0);
        expect_a("drop_en1", 8'h00, 1'b0, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        expect_a("rescan0", 8'h11, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        expect_a("rescan1", 8'h11, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd0);
        expect_a("rescan2", 8'h22, 1'b1, 2'd1);

        #2;
        rst_n = 1'b0;
        #1;
        expect_a("async_rst_a", 8'h00, 1'b0, 2'd0);
        expect_b("async_rst_b", 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 2'd3);
        expect_a("post_rst0", 8'h44, 1'b1, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        expect_a("post_rst1", 8'h44, 1'b1, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        expect_a("post_rst2", 8'h11, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd3);
        expect_a("post_rst3", 8'h11, 1'b1, 2'd0);

        step(1'b1, 1'b0, 2'd3);
        expect_b("ch3_manual_oob", 8'h00, 1'b0, 2'd3);
        expect_a("ch4_manual_se3", 8'h44, 1'b1, 2'd3);
        step(1'b1, 1'b1, 2'd3);
        expect_b("ch3_scan_start", 8'h11, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd3);
        expect_b("ch3_dwell1_adv", 8'h22, 1'b1, 2'd1);
        step(1'b1, 1'b1, 2'd3);
        expect_b("ch3_dwell1_adv2", 8'h33, 1'b1, 2'd2);
        step(1'b1, 1'b1, 2'd3);
        expect_b("ch3_wrap", 8'h11, 1'b1, 2'd0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            din_a = $urandom;
            din_b = 24'($urandom);
            en = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 9) == 0) begin
                mode = ~mode;
            end
            if ($urandom_range(0, 3) == 0) begin
                se = 2'($urandom);
            end
            @(negedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
